matmul_host_sequencer: RTL and testbench

//  Host-side initiator for MATRIX_MULTIPLIER's serial load / output-select interface.
//  - Latches two 3x3 4-bit matrices, then pulses the multiplier's reset.
//  - Streams 18 nibbles through i/ic, then issues 9 compute ic pulses.
//  - Steps os 0..8 and returns each 10-bit result on a one-cycle valid strobe.

---
 rtl/matmul_host_sequencer_pkg.sv | 15 +
 rtl/matmul_host_sequencer_if.sv | 12 +
 rtl/matmul_host_sequencer_phase_timer.sv | 18 +
 rtl/matmul_host_sequencer.sv | 118 +++++++++++
 tb/tb_matmul_host_sequencer.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/matmul_host_sequencer_pkg.sv
// matmul_host_sequencer_pkg: shared sizes, state encoding and helpers for the matmul host sequencer
package matmul_host_sequencer_pkg;
    localparam int N_LOAD = 18;
    localparam int N_COMP = 9;
    localparam int N_OUT  = 9;
    localparam int N_ELEM = N_LOAD + N_COMP;
    localparam int DATA_W = 4;
    localparam int RES_W  = 10;
    localparam int OS_W   = 4;
    localparam int MAT_W  = 9 * DATA_W;
    typedef enum logic [2:0] {IDLE, CLR, LSET, LHI, LLO, RSEL, RWAIT, DONE} state_t;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b ? a : b) > c ? (a > b ? a : b) : c;
    endfunction
endpackage

// File: rtl/matmul_host_sequencer_if.sv
// matmul_host_sequencer_if: serial load / output-select bus between the sequencer and the multiplier
interface matmul_host_sequencer_if;
    import matmul_host_sequencer_pkg::*;
    logic [DATA_W-1:0] mm_i;
    logic              mm_ic;
    logic [OS_W-1:0]   mm_os;
    logic              mm_en;
    logic              mm_mr;
    logic [RES_W-1:0]  m_in;
    modport master (output mm_i, mm_ic, mm_os, mm_en, mm_mr, input m_in);
    modport slave  (input mm_i, mm_ic, mm_os, mm_en, mm_mr, output m_in);
endinterface

// File: rtl/matmul_host_sequencer_phase_timer.sv
// matmul_host_sequencer_phase_timer: loadable down-counter; last is high on the final cycle of a dwell
module matmul_host_sequencer_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         last
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign last = cnt == W'(1);
endmodule

// File: rtl/matmul_host_sequencer.sv
// matmul_host_sequencer: streams two 3x3 matrices into the multiplier, runs it, and reads back the nine results
module matmul_host_sequencer
    import matmul_host_sequencer_pkg::*;
#(
    parameter int IC_HIGH   = 1,
    parameter int IC_LOW    = 1,
    parameter int OS_SETTLE = 2
) (
    input  logic                    clk,
    input  logic                    mr,
    input  logic                    start,
    input  logic [MAT_W-1:0]        a_flat,
    input  logic [MAT_W-1:0]        b_flat,
    matmul_host_sequencer_if.master bus,
    output logic                    res_valid,
    output logic [3:0]              res_idx,
    output logic [RES_W-1:0]        res_data,
    output logic                    busy,
    output logic                    done
);
    localparam int TW = $clog2(max3(IC_HIGH, IC_LOW, OS_SETTLE) + 1);
    state_t                         state;
    logic [N_LOAD-1:0][DATA_W-1:0]  shadow;
    logic [4:0]                     elem, elem_n;
    logic [3:0]                     idx;
    logic                           tload, tlast;
    logic [TW-1:0]                  tval;
    logic [DATA_W-1:0]              nib_n;
    assign elem_n = elem + 5'd1;
    // elements past the load phase are the compute strobes and carry a zero nibble
    assign nib_n  = elem_n < 5'(N_LOAD) ? shadow[elem_n] : '0;
    assign tload  = state == LSET || (state == LHI && tlast) || state == RSEL;
    assign tval   = state == LSET ? TW'(IC_HIGH) : state == LHI ? TW'(IC_LOW) : TW'(OS_SETTLE);
    matmul_host_sequencer_phase_timer #(.W(TW)) timer (
        .clk  (clk),
        .rst  (mr),
        .load (tload),
        .val  (tval),
        .last (tlast)
    );
    always_ff @(posedge clk) begin
        if (mr) begin
            state     <= IDLE;
            shadow    <= '0;
            elem      <= '0;
            idx       <= '0;
            bus.mm_i  <= '0;
            bus.mm_ic <= 1'b0;
            bus.mm_os <= '0;
            bus.mm_en <= 1'b0;
            bus.mm_mr <= 1'b0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    shadow    <= {b_flat, a_flat};
                    busy      <= 1'b1;
                    bus.mm_mr <= 1'b1;
                    bus.mm_en <= 1'b1;
                    state     <= CLR;
                end
                CLR: begin
                    bus.mm_mr <= 1'b0;
                    bus.mm_i  <= shadow[0];
                    bus.mm_ic <= 1'b0;
                    elem      <= '0;
                    idx       <= '0;
                    state     <= LSET;
                end
                LSET: begin
                    bus.mm_ic <= 1'b1;
                    state     <= LHI;
                end
                LHI: if (tlast) begin
                    bus.mm_ic <= 1'b0;
                    state     <= LLO;
                end
                LLO: if (tlast) begin
                    if (elem == 5'(N_ELEM - 1)) begin
                        bus.mm_os <= '0;
                        state     <= RSEL;
                    end else begin
                        elem     <= elem_n;
                        bus.mm_i <= nib_n;
                        state    <= LSET;
                    end
                end
                RSEL: state <= RWAIT;
                RWAIT: if (tlast) begin
                    res_data  <= bus.m_in;
                    res_idx   <= idx;
                    res_valid <= 1'b1;
                    if (idx == 4'(N_OUT - 1)) begin
                        done      <= 1'b1;
                        bus.mm_en <= 1'b0;
                        bus.mm_os <= '0;
                        state     <= DONE;
                    end else begin
                        idx       <= idx + 4'd1;
                        bus.mm_os <= idx + 4'd1;
                        state     <= RSEL;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_host_sequencer.sv
// tb_matmul_host_sequencer: two sequencers (default and slow timing) each driving a behavioural 3x3 multiplier
module tb_matmul_host_sequencer;
    localparam int ICH[2] = '{1, 2};
    localparam int ICL[2] = '{1, 3};
    localparam int OSS[2] = '{2, 1};
    localparam logic [35:0] A1 = 36'h000654541;
    localparam logic [35:0] B1 = 36'h4329ed7ba;
    localparam logic [9:0] S1[9] = '{10'd72, 10'd82, 10'd63, 10'd117, 10'd132, 10'd97, 10'd0, 10'd0, 10'd0};
    logic clk = 1'b0;
    logic mr;
    logic start[2];
    logic [35:0] a_fl[2], b_fl[2];
    logic res_valid[2], busy[2], done[2];
    logic [3:0] res_idx[2];
    logic [9:0] res_data[2];
    logic [27:0] outs_w[2];
    int ic_rise[2], i_bad[2], mr_rise[2], os_steps[2], os_bad[2], done_cnt[2];
    logic [13:0] exp_q[$];
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    function automatic logic [9:0] cexp(input logic [35:0] a, input logic [35:0] b, input int k);
        int s = 0;
        for (int j = 0; j < 3; j++) s += int'(a[4*(3*(k/3)+j) +: 4]) * int'(b[4*(3*j+k%3) +: 4]);
        return 10'(s);
    endfunction
    for (genvar g = 0; g < 2; g++) begin : gi
        matmul_host_sequencer_if bus();
        logic [3:0] mem[18];
        logic [4:0] cnt = '0;
        logic icm_q = 1'b0, ic_q = 1'b0, mr_q = 1'b0, en_q = 1'b0;
        logic [3:0] i_q = '0, os_q = '0;
        int run = 0, acc;
        matmul_host_sequencer #(.IC_HIGH(ICH[g]), .IC_LOW(ICL[g]), .OS_SETTLE(OSS[g])) dut (
            .clk(clk), .mr(mr), .start(start[g]), .a_flat(a_fl[g]), .b_flat(b_fl[g]), .bus(bus),
            .res_valid(res_valid[g]), .res_idx(res_idx[g]), .res_data(res_data[g]),
            .busy(busy[g]), .done(done[g])
        );
        assign outs_w[g] = {busy[g], done[g], res_valid[g], res_idx[g], res_data[g],
                            bus.mm_i, bus.mm_ic, bus.mm_os, bus.mm_en, bus.mm_mr};
        // multiplier model: 18 data nibbles then 9 compute strobes, each on an ic rising edge
        always @(posedge clk) begin
            icm_q <= bus.mm_ic;
            if (bus.mm_mr) cnt <= '0;
            else if (bus.mm_ic && !icm_q) begin
                if (cnt < 5'd18) mem[cnt] <= bus.mm_i;
                if (cnt < 5'd31) cnt <= cnt + 5'd1;
            end
        end
        always_comb begin
            acc = 0;
            for (int j = 0; j < 3; j++)
                acc += int'(mem[3*(int'(bus.mm_os)/3)+j]) * int'(mem[9+3*j+int'(bus.mm_os)%3]);
            bus.m_in = (cnt >= 5'd27 && bus.mm_os < 4'd9) ? 10'(acc) : '0;
        end
        always @(negedge clk) begin
            ic_q <= bus.mm_ic;
            mr_q <= bus.mm_mr;
            en_q <= bus.mm_en;
            i_q  <= bus.mm_i;
            os_q <= bus.mm_os;
            if (bus.mm_ic && !ic_q) ic_rise[g] <= ic_rise[g] + 1;
            if (bus.mm_ic && ic_q && bus.mm_i != i_q) i_bad[g] <= i_bad[g] + 1;
            if (bus.mm_mr && !mr_q) mr_rise[g] <= mr_rise[g] + 1;
            if (done[g]) done_cnt[g] <= done_cnt[g] + 1;
            if (bus.mm_en && bus.mm_os != os_q) begin
                os_steps[g] <= os_steps[g] + 1;
                if (bus.mm_os != os_q + 4'd1 || (os_q != 4'd0 && run != 1 + OSS[g])) os_bad[g] <= os_bad[g] + 1;
                run <= 1;
            end else begin
                if (en_q && !bus.mm_en && run != 1 + OSS[g]) os_bad[g] <= os_bad[g] + 1;
                run <= run + 1;
            end
            if (res_valid[g]) chk("result", {res_idx[g], res_data[g]}, exp_q.size() != 0 ? exp_q.pop_front() : 14'h3fff);
        end
    end
    task automatic job(input int s, input logic [35:0] a, input logic [35:0] b, input bit hold, input bit lit);
        int cyc, ic0, ib0, mr0, st0, ob0, dn0;
        ic0 = ic_rise[s]; ib0 = i_bad[s]; mr0 = mr_rise[s];
        st0 = os_steps[s]; ob0 = os_bad[s]; dn0 = done_cnt[s];
        for (int k = 0; k < 9; k++) exp_q.push_back({4'(k), lit ? S1[k] : cexp(a, b, k)});
        @(negedge clk);
        a_fl[s] = a; b_fl[s] = b; start[s] = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("busy_on", busy[s], 1);
                a_fl[s] = ~a; b_fl[s] = ~b;
                if (!hold) start[s] = 1'b0;
            end
        end while (!done[s] && cyc < 1000);
        start[s] = 1'b0;
        chk("latency", cyc, 2 + 27 * (1 + ICH[s] + ICL[s]) + 9 * (1 + OSS[s]));
        chk("busy_done", busy[s], 1);
        repeat (4) @(negedge clk);
        chk("busy_off", busy[s], 0);
        chk("sb_drain", exp_q.size(), 0);
        chk("done_once", done_cnt[s] - dn0, 1);
        chk("ic_edges", ic_rise[s] - ic0, 27);
        chk("i_stable", i_bad[s] - ib0, 0);
        chk("mr_pulses", mr_rise[s] - mr0, 1);
        chk("os_steps", os_steps[s] - st0, 8);
        chk("os_hold", os_bad[s] - ob0, 0);
    endtask
    initial begin
        int dn0;
        mr = 1'b1;
        start = '{1'b0, 1'b0};
        a_fl = '{36'd0, 36'd0};
        b_fl = '{36'd0, 36'd0};
        repeat (3) @(negedge clk);
        chk("reset0", outs_w[0], 0);
        chk("reset1", outs_w[1], 0);
        mr = 1'b0;
        @(negedge clk);
        job(0, A1, B1, 1'b0, 1'b1);
        job(0, {36{1'b1}}, {36{1'b1}}, 1'b0, 1'b0);
        job(0, 36'({$urandom(), $urandom()}), 36'({$urandom(), $urandom()}), 1'b1, 1'b0);
        dn0 = done_cnt[0];
        @(negedge clk);
        a_fl[0] = A1; b_fl[0] = B1; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (39) @(negedge clk);
        mr = 1'b1;
        @(negedge clk);
        chk("abort_zero", outs_w[0], 0);
        mr = 1'b0;
        repeat (150) @(negedge clk);
        chk("abort_no_done", done_cnt[0] - dn0, 0);
        chk("abort_idle", busy[0], 0);
        job(0, A1, B1, 1'b0, 1'b1);
        job(1, A1, B1, 1'b0, 1'b1);
        job(1, 36'({$urandom(), $urandom()}), 36'({$urandom(), $urandom()}), 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
